// File: rtl/frame_deframer.sv
// Receive-side deframer: hunts for SYNC, assembles a 4-byte payload,
// checks a trailing CRC-8 (poly 0xD5, init 0) and offers good frames on a
// single-entry valid/ready output slot.
//
// state   | meaning
// --------+-----------------------------------------------------------
// HUNT    | waiting for SYNC_BYTE, all other bytes ignored
// PAYLOAD | shifting in payload bytes and accumulating the CRC
// CHECK   | next byte is the CRC; compare, deliver or flag, then HUNT
module frame_deframer #(
  parameter logic [7:0] SYNC_BYTE     = 8'hA5,
  parameter int         PAYLOAD_BYTES = 4,
  parameter int         TIMEOUT       = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        crc_err,
  output logic        timeout_err,
  output logic        overflow
);

  localparam int IW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [7:0]      crc;
  logic [31:0]     shift_in;
  logic [2:0]      byte_cnt;
  logic [IW-1:0]   idle_cnt;
  logic            idle_hit;
  logic            load;
  logic            crc_err_nx;
  logic            timeout_nx;
  logic            overflow_nx;

  // One bytewise CRC-8 update, MSB first.
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ({r[6:0], 1'b0} ^ 8'hD5) : {r[6:0], 1'b0};
    end
    return r;
  endfunction

  // A byte arriving on the timeout cycle takes priority, so in_valid masks the hit.
  assign idle_hit = (state != HUNT) && !in_valid && (idle_cnt == IW'(TIMEOUT));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_nx;
  end

  // Next-state decode and per-cycle frame outcome.
  always_comb begin
    state_nx    = state;
    load        = 1'b0;
    crc_err_nx  = 1'b0;
    timeout_nx  = 1'b0;
    overflow_nx = 1'b0;
    case (state)
      HUNT: begin
        if (in_valid && in_byte == SYNC_BYTE) state_nx = PAYLOAD;
      end
      PAYLOAD: begin
        if (in_valid) begin
          if (byte_cnt == 3'(PAYLOAD_BYTES - 1)) state_nx = CHECK;
        end else if (idle_hit) begin
          timeout_nx = 1'b1;
          state_nx   = HUNT;
        end
      end
      CHECK: begin
        if (in_valid) begin
          state_nx = HUNT;
          if (in_byte == crc) begin
            if (!out_valid || out_ready) load = 1'b1;
            else                         overflow_nx = 1'b1;
          end else begin
            crc_err_nx = 1'b1;
          end
        end else if (idle_hit) begin
          timeout_nx = 1'b1;
          state_nx   = HUNT;
        end
      end
      default: state_nx = HUNT;
    endcase
  end

  // Assembly datapath: shift register, CRC accumulator, byte and idle counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc      <= 8'h00;
      shift_in <= 32'h0;
      byte_cnt <= 3'd0;
      idle_cnt <= '0;
    end else begin
      if (state == HUNT) begin
        if (in_valid && in_byte == SYNC_BYTE) begin
          crc      <= 8'h00;
          byte_cnt <= 3'd0;
          idle_cnt <= '0;
        end
      end else begin
        if (in_valid)                       idle_cnt <= '0;
        else if (idle_cnt != IW'(TIMEOUT))  idle_cnt <= idle_cnt + 1'b1;
        if (state == PAYLOAD && in_valid) begin
          shift_in <= {shift_in[23:0], in_byte};
          crc      <= crc8_step(crc, in_byte);
          byte_cnt <= byte_cnt + 3'd1;
        end
      end
    end
  end

  // Output slot and registered status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data    <= 32'h0;
      out_valid   <= 1'b0;
      crc_err     <= 1'b0;
      timeout_err <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      crc_err     <= crc_err_nx;
      timeout_err <= timeout_nx;
      overflow    <= overflow_nx;
      if (load) begin
        out_data  <= shift_in;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frame_deframer.sv
// Bench for frame_deframer: directed table, hand-written corner sequences,
// then random traffic against a queue-based frame model.
module tb_frame_deframer;

  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        crc_err;
  logic        timeout_err;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  frame_deframer #(.SYNC_BYTE(8'hA5), .PAYLOAD_BYTES(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .crc_err(crc_err), .timeout_err(timeout_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference CRC over a whole payload, computed arithmetically.
  function automatic logic [7:0] crc8(input logic [7:0] q[$]);
    int c;
    c = 0;
    foreach (q[i]) begin
      c = c ^ int'(q[i]);
      for (int k = 0; k < 8; k++) begin
        if (c >= 128) c = ((c * 2) % 256) ^ 'hD5;
        else          c = (c * 2) % 256;
      end
    end
    return 8'(c);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_byte  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] p, input logic [7:0] c);
    send_byte(8'hA5);
    send_byte(p[31:24]);
    send_byte(p[23:16]);
    send_byte(p[15:8]);
    send_byte(p[7:0]);
    send_byte(c);
  endtask

  // ---------------- behavioural model ----------------
  bit          m_coll;
  logic [7:0]  mq[$];
  int          m_gap;
  logic        m_valid, m_crc_e, m_tmo, m_ovf;
  logic [31:0] m_data;

  task automatic model_reset();
    m_coll = 0; mq.delete(); m_gap = 0;
    m_valid = 0; m_data = 0; m_crc_e = 0; m_tmo = 0; m_ovf = 0;
  endtask

  task automatic model_step(input logic iv, input logic [7:0] ib, input logic rdy);
    bit load, acc;
    load = 0;
    acc  = m_valid && rdy;
    m_crc_e = 0; m_tmo = 0; m_ovf = 0;
    if (!m_coll) begin
      if (iv && ib == 8'hA5) begin
        m_coll = 1; mq.delete(); m_gap = 0;
      end
    end else if (iv) begin
      m_gap = 0;
      if (mq.size() < 4) mq.push_back(ib);
      else begin
        m_coll = 0;
        if (crc8(mq) == ib) begin
          if (!m_valid || rdy) load = 1;
          else                 m_ovf = 1;
        end else m_crc_e = 1;
      end
    end else if (m_gap == TIMEOUT) begin
      m_tmo = 1; m_coll = 0;
    end else m_gap++;
    if (load) begin
      m_data  = {mq[0], mq[1], mq[2], mq[3]};
      m_valid = 1;
    end else if (acc) m_valid = 0;
  endtask

  // -1 entries are idle cycles, others are bytes.
  int stim[$];

  task automatic gen_item();
    int r;
    logic [7:0] p[$];
    r = $urandom_range(0, 19);
    if (r < 12) begin
      p.delete();
      stim.push_back(8'hA5);
      for (int i = 0; i < 4; i++) begin
        p.push_back(($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom));
        repeat ($urandom_range(0, 2)) stim.push_back(-1);
        stim.push_back(int'(p[i]));
      end
      if (r < 8) stim.push_back(int'(crc8(p)));
      else       stim.push_back(int'(crc8(p) ^ 8'($urandom_range(1, 255))));
    end else if (r < 15) begin
      repeat ($urandom_range(1, 4)) stim.push_back(int'(8'($urandom)));
    end else if (r == 15) begin
      stim.push_back(8'hA5);
      repeat ($urandom_range(1, 4)) stim.push_back(int'(8'($urandom)));
      repeat ($urandom_range(TIMEOUT - 1, TIMEOUT + 2)) stim.push_back(-1);
    end else begin
      repeat ($urandom_range(1, 5)) stim.push_back(-1);
    end
  endtask

  typedef struct {
    logic [31:0] payload;
    logic [7:0]  crc;
    logic        good;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic acc_tmo;
    int v;
    tbl[0] = '{32'h0000_0001, 8'hD5, 1'b1};
    tbl[1] = '{32'h0100_0000, 8'h46, 1'b0};
    tbl[2] = '{32'h0100_0000, 8'h45, 1'b1};
    tbl[3] = '{32'h0000_0000, 8'h00, 1'b1};
    tbl[4] = '{32'h0000_0000, 8'h01, 1'b0};
    tbl[5] = '{32'h0000_0001, 8'hD4, 1'b0};

    // reset state
    idle(3);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_pulses", {crc_err, timeout_err, overflow}, 0);
    rst_n = 1'b1;
    idle(1);

    // directed table
    out_ready = 1'b1;
    foreach (tbl[i]) begin
      send_frame(tbl[i].payload, tbl[i].crc);
      check("tbl_valid", out_valid, tbl[i].good);
      check("tbl_crc_err", crc_err, !tbl[i].good);
      if (tbl[i].good) check("tbl_data", out_data, tbl[i].payload);
      idle(1);
      check("tbl_accepted", out_valid, 0);
      check("tbl_pulse_width", crc_err, 0);
    end

    // junk before sync is ignored
    send_byte(8'h3C); send_byte(8'h5A); send_byte(8'hFF);
    send_frame(32'h0, 8'h00);
    check("junk_valid", out_valid, 1);
    check("junk_data", out_data, 32'h0);
    check("junk_pulses", {crc_err, timeout_err, overflow}, 0);
    idle(1);

    // overflow while slot is held
    out_ready = 1'b0;
    send_frame(32'h0000_0001, 8'hD5);
    check("ovf_first_valid", out_valid, 1);
    send_frame(32'h0, 8'h00);
    check("ovf_pulse", overflow, 1);
    check("ovf_data_held", out_data, 32'h0000_0001);
    idle(1);
    check("ovf_pulse_end", overflow, 0);
    check("ovf_still_valid", out_valid, 1);
    out_ready = 1'b1;
    idle(1);
    check("ovf_drained", out_valid, 0);

    // simultaneous accept and load
    out_ready = 1'b0;
    send_frame(32'h0000_0001, 8'hD5);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    out_ready = 1'b1;
    send_byte(8'h00);
    out_ready = 1'b0;
    check("simul_no_ovf", overflow, 0);
    check("simul_valid", out_valid, 1);
    check("simul_data", out_data, 32'h0);
    idle(1);
    check("simul_held", out_valid, 1);
    out_ready = 1'b1;
    idle(1);
    check("simul_drained", out_valid, 0);

    // timeout after TIMEOUT+1 idle cycles
    send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34);
    acc_tmo = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      idle(1);
      acc_tmo |= timeout_err;
    end
    check("tmo_not_early", acc_tmo, 0);
    idle(1);
    check("tmo_pulse", timeout_err, 1);
    idle(1);
    check("tmo_pulse_end", timeout_err, 0);
    send_frame(32'h0000_0001, 8'hD5);
    check("tmo_recover", out_data, 32'h0000_0001);
    check("tmo_recover_valid", out_valid, 1);
    idle(1);

    // byte on the timeout cycle wins
    send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34);
    acc_tmo = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      idle(1);
      acc_tmo |= timeout_err;
    end
    send_byte(8'h56);
    acc_tmo |= timeout_err;
    send_byte(8'h78);
    begin
      logic [7:0] q[$];
      q = '{8'h12, 8'h34, 8'h56, 8'h78};
      send_byte(crc8(q));
    end
    acc_tmo |= timeout_err;
    check("tmo_edge_none", acc_tmo, 0);
    check("tmo_edge_data", out_data, 32'h1234_5678);
    check("tmo_edge_valid", out_valid, 1);
    idle(1);

    // reset mid-payload and with a held frame
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h00); send_byte(8'h01); send_byte(8'hD5);
    check("rst_mid_discard", out_valid, 0);
    out_ready = 1'b0;
    send_frame(32'h0000_0001, 8'hD5);
    check("rst_hold_pre", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rst_hold_valid", out_valid, 0);
    check("rst_hold_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send_frame(32'h0100_0000, 8'h45);
    check("rst_after_data", out_data, 32'h0100_0000);
    check("rst_after_valid", out_valid, 1);

    // random traffic against the model
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    model_reset();
    for (int cyc = 0; cyc < 8000; cyc++) begin
      if (stim.size() == 0) gen_item();
      v = stim.pop_front();
      in_valid  = (v >= 0);
      in_byte   = (v >= 0) ? 8'(v) : 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      model_step(in_valid, in_byte, out_ready);
      @(negedge clk);
      check("rand_flags", {out_valid, crc_err, timeout_err, overflow},
            {m_valid, m_crc_e, m_tmo, m_ovf});
      check("rand_data", out_data, m_data);
    end
    in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
